w21_col_mac: RTL and testbench
==============================

# w21_col_mac

Sequencer and multiply-accumulate engine that reads one 300-entry weight column ROM (9-bit address, 21-bit signed weight) and dots it with a 300-element activation stream. The ROM is combinational, so the block drives its address and consumes the weight in the same cycle. The block sits between the activation buffer (valid/ready source) and the next-layer input (valid/ready sink). One instance serves one column ROM.

## Interface
- DEPTH, 300: number of ROM entries and stream length; addresses run 0..DEPTH-1.
- ADDR_W, 9: ROM address width.
- W_W, 21: signed weight width.
- X_W, 16: signed activation width.
- ACC_W, 48: signed accumulator and result width.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new dot product; honored only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE next cycle with no result.
- x_valid  in  1  activation beat valid.
- x_data  in  X_W  signed activation.
- x_ready  out  1  block accepts a beat this cycle.
- adrs_clm  out  ADDR_W  ROM address, registered.
- w_in  in  W_W  signed ROM data for the current adrs_clm.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  sink accepts the result.
- acc_out  out  ACC_W  signed dot-product result.
- done  out  1  one-cycle pulse on the first cycle out_valid is high.

## Operation
- Reset values: state IDLE; adrs_clm=0, x_ready=0, busy=0, out_valid=0, done=0, acc_out=0. The product register and the accumulator reset to 0.
- States:
  - IDLE: on start, clear the accumulator and the product-valid flag, set adrs_clm=0, go to RUN.
  - RUN: x_ready=1. On a beat (x_valid&&x_ready), register product = x_data*w_in (signed, X_W+W_W=37 bits). Set the product-valid flag.
    - If adrs_clm<DEPTH-1, increment adrs_clm.
    - If adrs_clm==DEPTH-1, go to DRAIN and reset adrs_clm to 0.
    - With no beat, hold the address and clear the product-valid flag.
  - DRAIN: x_ready=0. Stay exactly 1 cycle while the last product is added, then go to HOLD.
  - HOLD: out_valid=1 and acc_out=accumulator, stable until out_valid&&out_ready. Then go to IDLE and drop out_valid.
- Accumulate rule: each cycle the product-valid flag is set, the accumulator adds the sign-extended product. No saturation is needed, because 300·2^36 < 2^47.
- acc_out is the accumulator register; it is meaningful only while out_valid=1.
- start outside IDLE is ignored, including on the HOLD-exit cycle. A new run needs start in IDLE.
- abort in RUN/DRAIN/HOLD: next cycle state=IDLE, out_valid=0, adrs_clm=0, and no done pulse. abort in IDLE has no effect. abort and start together in IDLE: abort wins and the block stays IDLE.
- x_valid gaps are allowed anywhere. The address advances only on accepted beats, so weight k is always paired with the k-th accepted beat.
- rst_n low at any time, including mid-run, forces reset values immediately. Operation resumes only via a new start after release.

## Timing
- start sampled high in IDLE at cycle S: RUN and x_ready=1 in cycle S+1 with adrs_clm=0.
- Beat at cycle t: product registered at the end of t, accumulated at the end of t+1.
- Last beat (address DEPTH-1) at cycle T: DRAIN in T+1, out_valid=1 and done=1 in T+2. done is low from T+3 onward.
- Minimum run: start, then 300 back-to-back beats. Total time from the start cycle to out_valid is 302 cycles.
- Handshake: acc_out must not change while out_valid=1 && !out_ready.
- Throughput: one beat per cycle in RUN. x_ready is never high outside RUN.

## Test plan
- Impulse at 0: start; x=1 at beat 0 and x=0 for beats 1..299, back-to-back. Required: acc_out=-16, and out_valid/done rise exactly 2 cycles after beat 299.
- Impulse at 7: x=1 at beat 7 and 0 elsewhere. Required: acc_out=+304. Also x=-1000 at beat 196 and 0 elsewhere. Required: acc_out=0 (the weight there is 0).
- All-ones and random streams with random x_valid gaps and random out_ready stalls. Required: acc_out equals a golden sum Σ x_k·w_k. adrs_clm advances only on beats. acc_out stays stable while stalled.
- Extremes: x=-32768 on all 300 beats. Required: exact 48-bit result with no wrap, compared against the golden model.
- Abort and reset: abort at beat 150. Required: IDLE next cycle, no done, and a following clean run gives the correct result. rst_n low mid-RUN. Required: all outputs at reset values immediately.
- Protocol corners: start held high during RUN/HOLD is ignored. start held on the HOLD-exit cycle does not restart; start one cycle later does. A second run's result is independent of the first (the accumulator is cleared).

Source files
------------

// File: rtl/w21_col_mac.sv
// Column MAC sequencer: walks a combinational weight ROM in lock-step with an
// activation stream and returns the signed dot product over a valid/ready port.
module w21_col_mac #(
    parameter int DEPTH  = 300,
    parameter int ADDR_W = 9,
    parameter int W_W    = 21,
    parameter int X_W    = 16,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              x_valid,
    input  logic [X_W-1:0]    x_data,
    output logic              x_ready,
    output logic [ADDR_W-1:0] adrs_clm,
    input  logic [W_W-1:0]    w_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              done
);

    localparam int P_W = X_W + W_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t                  state;
    logic signed [P_W-1:0]   prod;
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc;

    logic                  beat;
    logic                  go_idle;
    logic signed [P_W-1:0] prod_next;

    assign beat      = x_valid && x_ready;
    assign go_idle   = (state != IDLE) && (abort || (state == HOLD && out_ready));
    // Both operands are sign-extended to the full product width before multiplying.
    assign prod_next = P_W'($signed(x_data)) * P_W'($signed(w_in));
    assign acc_out   = acc;

    // NOTE: every register here, including the accumulator and the product
    // pipeline, has an explicit reset value; none of them is a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            adrs_clm  <= '0;
            x_ready   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            prod      <= '0;
            prod_vld  <= 1'b0;
            acc       <= '0;
        end else begin
            // NOTE: non-blocking assignments only; later writes in this block
            // (e.g. the accumulator clear on start) override the default update.
            done <= 1'b0;
            if (prod_vld) acc <= acc + ACC_W'(prod);

            if (go_idle) begin
                state     <= IDLE;
                adrs_clm  <= '0;
                x_ready   <= 1'b0;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                prod_vld  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state    <= RUN;
                            acc      <= '0;
                            prod_vld <= 1'b0;
                            adrs_clm <= '0;
                            x_ready  <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (beat) begin
                            prod     <= prod_next;
                            prod_vld <= 1'b1;
                            if (adrs_clm == LAST_ADDR) begin
                                state    <= DRAIN;
                                adrs_clm <= '0;
                                x_ready  <= 1'b0;
                            end else begin
                                adrs_clm <= adrs_clm + 1'b1;
                            end
                        end else begin
                            prod_vld <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        // The final product lands in the accumulator this cycle.
                        prod_vld  <= 1'b0;
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        done      <= 1'b1;
                    end
                    HOLD: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_w21_col_mac.sv
// Self-checking bench for w21_col_mac: transaction-level model plus per-cycle
// output compare, directed impulse/extreme/abort/reset/protocol vectors.
`timescale 1ns/1ps
module tb_w21_col_mac;

    localparam int DEPTH  = 300;
    localparam int ADDR_W = 9;
    localparam int W_W    = 21;
    localparam int X_W    = 16;
    localparam int ACC_W  = 48;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              x_valid = 1'b0;
    logic [X_W-1:0]    x_data = '0;
    logic              out_ready = 1'b0;
    logic              x_ready, busy, out_valid, done;
    logic [ADDR_W-1:0] adrs_clm;
    logic [W_W-1:0]    w_in;
    logic [ACC_W-1:0]  acc_out;

    logic [W_W-1:0] rom [512];
    assign w_in = rom[adrs_clm];

    always #5 clk = ~clk;

    w21_col_mac #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W_W(W_W), .X_W(X_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .adrs_clm(adrs_clm), .w_in(w_in), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .done(done)
    );

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HOLD} mphase_t;

    mphase_t ph      = M_IDLE;
    int      m_addr  = 0;
    longint  m_sum   = 0;
    bit      m_first = 1'b0;
    int      cyc     = 0;
    int      compared   = 0;
    int      mismatched = 0;
    longint  vec [DEPTH];

    function automatic longint wv(int k);
        logic signed [W_W-1:0] s;
        s = rom[k];
        return longint'(s);
    endfunction

    function automatic longint golden_dot();
        longint s = 0;
        for (int k = 0; k < DEPTH; k++) s += vec[k] * wv(k);
        return s;
    endfunction

    function automatic longint acc_s();
        logic signed [ACC_W-1:0] s;
        s = acc_out;
        return longint'(s);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; the model moves by the rules of the block using the
    // inputs currently presented.
    task automatic step();
        mphase_t np = ph;
        int      na = m_addr;
        longint  ns = m_sum;
        bit      nf = 1'b0;
        if (!rst_n) begin
            np = M_IDLE;
            na = 0;
        end else begin
            case (ph)
                M_IDLE: if (start && !abort) begin np = M_RUN; na = 0; ns = 0; end
                M_RUN: begin
                    if (abort) begin
                        np = M_IDLE; na = 0;
                    end else if (x_valid) begin
                        ns = m_sum + longint'($signed(x_data)) * wv(m_addr);
                        if (m_addr == DEPTH - 1) begin np = M_DRAIN; na = 0; end
                        else na = m_addr + 1;
                    end
                end
                M_DRAIN: if (abort) np = M_IDLE; else begin np = M_HOLD; nf = 1'b1; end
                M_HOLD:  if (abort || out_ready) np = M_IDLE;
            endcase
        end
        @(posedge clk);
        ph = np; m_addr = na; m_sum = ns; m_first = nf; cyc++;
        @(negedge clk);
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [3:0] exp_flags;
        exp_flags = {ph != M_IDLE, ph == M_RUN, ph == M_HOLD, ph == M_HOLD && m_first};
        check("flags{busy,x_ready,out_valid,done}", longint'({busy, x_ready, out_valid, done}),
              longint'(exp_flags));
        check("adrs_clm", longint'(adrs_clm), longint'(m_addr));
        if (ph == M_HOLD) check("acc_out_hold", acc_s(), m_sum);
    end

    task automatic run(input int gap_pct, input int stall_pct, input bit hold_start,
                       input int abort_at, output longint res);
        int t_start = 0;
        int t_last  = 0;
        int n       = 0;
        res = 0;
        start = 1'b1;
        t_start = cyc;
        step();
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            while ($urandom_range(99) < gap_pct) begin x_valid = 1'b0; step(); end
            x_valid = 1'b1;
            x_data  = X_W'(vec[k]);
            if (k == abort_at) begin
                abort = 1'b1; step(); abort = 1'b0; x_valid = 1'b0;
                check("abort_busy", longint'(busy), 0);
                check("abort_no_done", longint'(done), 0);
                return;
            end
            t_last = cyc;
            step();
        end
        x_valid = 1'b0;
        while (!out_valid && n < 8) begin step(); n++; end
        check("lat_last_beat", longint'(cyc - t_last), 2);
        if (gap_pct == 0) check("lat_start", longint'(cyc - t_start), 302);
        check("done_first", longint'(done), 1);
        res = acc_s();
        check("golden", res, golden_dot());
        if (abort_at == DEPTH) begin
            abort = 1'b1; step(); abort = 1'b0;
            check("abort_hold_ov", longint'(out_valid), 0);
            return;
        end
        for (int i = 0; i < 50 && ph == M_HOLD; i++) begin
            out_ready = (i >= 40) || ($urandom_range(99) >= stall_pct);
            step();
            if (ph == M_HOLD) check("stall_stable", acc_s(), res);
        end
        out_ready = 1'b0;
        check("exit_idle", longint'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint res;
        for (int k = 0; k < 512; k++)
            rom[k] = (k < DEPTH) ? W_W'(((k * 40503 + 977) % 2097152) - 1048576) : '0;
        rom[0]   = W_W'(-16);
        rom[1]   = W_W'(-1048576);
        rom[2]   = W_W'(1048575);
        rom[7]   = W_W'(304);
        rom[196] = '0;

        repeat (3) step();
        check("rst_acc", acc_s(), 0);
        check("rst_flags", longint'({busy, x_ready, out_valid, done}), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check("abort_wins_idle", longint'(busy), 0);

        foreach (vec[k]) vec[k] = 0;
        vec[0] = 1;
        run(0, 0, 1'b0, -1, res);
        check("impulse0", res, -16);

        foreach (vec[k]) vec[k] = 0;
        vec[7] = 1;
        run(0, 30, 1'b0, -1, res);
        check("impulse7", res, 304);

        foreach (vec[k]) vec[k] = 0;
        vec[196] = -1000;
        run(0, 0, 1'b0, -1, res);
        check("impulse196", res, 0);

        foreach (vec[k]) vec[k] = 1;
        run(30, 50, 1'b0, -1, res);

        foreach (vec[k]) vec[k] = longint'($signed(16'($urandom)));
        run(25, 60, 1'b0, -1, res);

        foreach (vec[k]) vec[k] = -32768;
        run(0, 0, 1'b0, -1, res);
        check("extreme_nonzero", longint'(res != 0), 1);

        // abort mid-RUN, then a clean run
        foreach (vec[k]) vec[k] = longint'($signed(16'($urandom)));
        run(0, 0, 1'b0, 150, res);
        repeat (2) step();
        run(10, 20, 1'b0, -1, res);

        // abort while holding the result
        run(0, 0, 1'b0, DEPTH, res);
        step();

        // reset mid-RUN
        start = 1'b1; step(); start = 1'b0;
        x_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin x_data = X_W'(k * 3 - 7); step(); end
        #2 rst_n = 1'b0;
        ph = M_IDLE; m_addr = 0;
        #1;
        check("rst_mid_flags", longint'({busy, x_ready, out_valid, done}), 0);
        check("rst_mid_addr", longint'(adrs_clm), 0);
        check("rst_mid_acc", acc_s(), 0);
        x_valid = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        foreach (vec[k]) vec[k] = (k % 5) - 2;
        run(5, 30, 1'b0, -1, res);

        // start held through RUN/HOLD and the HOLD-exit cycle
        foreach (vec[k]) vec[k] = longint'($signed(16'($urandom)));
        run(10, 40, 1'b1, -1, res);
        step();
        check("restart_after_exit", longint'(busy), 1);
        start = 1'b0; abort = 1'b1; step(); abort = 1'b0;
        check("abort_early_run", longint'(busy), 0);

        // a later run is independent of earlier ones
        foreach (vec[k]) vec[k] = 0;
        vec[7] = 1;
        run(0, 0, 1'b0, -1, res);
        check("impulse7_again", res, 304);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
